// File: rtl/traffic_phase_timer_pkg.sv
// traffic_pkg: shared timer state encoding and default phase durations.
package traffic_pkg;
    typedef enum logic [1:0] {IDLE, RUN_S, RUN_L, DONE} phase_timer_state_e;
    localparam int SHORT_CYC_DEF = 5;
    localparam int LONG_CYC_DEF  = 20;
endpackage

// File: rtl/traffic_phase_timer_if.sv
// traffic_phase_timer_if: link between the traffic FSM (master) and the phase timer (slave).
interface traffic_phase_timer_if #(parameter int CNT_W = 8);
    logic             ST;
    logic             TS;
    logic             TL;
    logic             C;
    logic             busy;
    logic [CNT_W-1:0] cnt;
    modport master (output ST, input TS, TL, C, busy, cnt);
    modport slave  (input ST, output TS, TL, C, busy, cnt);
endinterface

// File: rtl/traffic_phase_timer_sensor_debounce.sv
// sensor_debounce: 2-flop synchroniser followed by a stable-count debouncer.
module sensor_debounce #(
    parameter int DEB_CYC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q
);
    localparam int DW = $clog2(DEB_CYC + 1);
    logic [1:0]    sync_q, sync_d;
    logic [DW-1:0] deb_q, deb_d;
    logic          q_q, q_d;
    logic          c_s;
    assign c_s = sync_q[1];
    always_comb begin
        sync_d = {sync_q[0], d_async};
        deb_d  = (c_s != q_q) ? deb_q + 1'b1 : '0;
        q_d    = q_q;
        if (deb_d == DW'(DEB_CYC)) begin
            q_d   = c_s;
            deb_d = '0;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            deb_q  <= '0;
            q_q    <= 1'b0;
        end else begin
            sync_q <= sync_d;
            deb_q  <= deb_d;
            q_q    <= q_d;
        end
    end
    assign q = q_q;
endmodule

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: short/long phase interval timer plus debounced car sensor.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int SHORT_CYC = SHORT_CYC_DEF,
    parameter int LONG_CYC  = LONG_CYC_DEF,
    parameter int CNT_W     = 8,
    parameter int DEB_CYC   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  C_raw,
    traffic_phase_timer_if.slave  bus
);
    if (!(SHORT_CYC < LONG_CYC && LONG_CYC < 2**CNT_W)) begin : g_bad_cyc
        $error("traffic_phase_timer: need SHORT_CYC < LONG_CYC < 2**CNT_W");
    end
    if (DEB_CYC < 1) begin : g_bad_deb
        $error("traffic_phase_timer: DEB_CYC must be >= 1");
    end
    phase_timer_state_e state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    always_comb begin
        cnt_inc = cnt_q + 1'b1;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.ST) begin
            state_d = RUN_S;
            cnt_d   = '0;
        end else if (state_q == RUN_S) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == CNT_W'(SHORT_CYC)) ? RUN_L : RUN_S;
        end else if (state_q == RUN_L) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == CNT_W'(LONG_CYC)) ? DONE : RUN_L;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // Outputs decode registered state only, so ST never reaches them combinationally.
    assign bus.TS   = (state_q == RUN_L) || (state_q == DONE);
    assign bus.TL   = (state_q == DONE);
    assign bus.busy = (state_q == RUN_S) || (state_q == RUN_L);
    assign bus.cnt  = cnt_q;
    sensor_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
        .clk     (clk),
        .rst     (rst),
        .d_async (C_raw),
        .q       (bus.C)
    );
endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb_traffic_phase_timer: vector table, debounce/reset sequences and random run vs a timeline model.
module tb_traffic_phase_timer;
    import traffic_pkg::*;
    localparam int SH  = SHORT_CYC_DEF;
    localparam int LG  = LONG_CYC_DEF;
    localparam int DEB = 3;
    localparam int W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic c_raw = 1'b0;

    traffic_phase_timer_if #(.CNT_W(W)) bus();

    traffic_phase_timer #(.SHORT_CYC(SH), .LONG_CYC(LG), .CNT_W(W), .DEB_CYC(DEB)) dut (
        .clk   (clk),
        .rst   (rst),
        .C_raw (c_raw),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: time since the last ST-high edge, plus the raw sensor sample history.
    bit started;
    int el;
    int n;
    bit cm;
    int last_chg;
    bit rawh [0:8191];

    typedef struct {
        int st_cyc;
        int ncyc;
        bit ts;
        bit tl;
        bit busy;
        int cnt;
    } vec_t;
    vec_t tbl [18];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic bit cs(input int j);
        return (j - 2 < 1) ? 1'b0 : rawh[j-2];
    endfunction

    task automatic model_reset();
        started = 0; el = 0; n = 0; cm = 0; last_chg = 0;
    endtask

    task automatic model_edge();
        bit ok;
        n++;
        rawh[n] = c_raw;
        if (bus.ST) begin
            started = 1;
            el = 0;
        end else if (started && el < LG) el++;
        ok = 1;
        for (int j = n - DEB + 1; j <= n; j++)
            if (j <= last_chg || cs(j) == cm) ok = 0;
        if (ok) begin
            cm = !cm;
            last_chg = n;
        end
    endtask

    task automatic check_model();
        chk("model TS",   {31'd0, bus.TS},   {31'd0, started && el >= SH});
        chk("model TL",   {31'd0, bus.TL},   {31'd0, started && el >= LG});
        chk("model busy", {31'd0, bus.busy}, {31'd0, started && el < LG});
        chk("model cnt",  {24'd0, bus.cnt},  el);
        chk("model C",    {31'd0, bus.C},    {31'd0, cm});
    endtask

    task automatic step(input bit st, input bit cr);
        bus.ST = st;
        c_raw  = cr;
        @(posedge clk);
        model_edge();
        #1 check_model();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " TS"},   {31'd0, bus.TS},   0);
        chk({tag, " TL"},   {31'd0, bus.TL},   0);
        chk({tag, " busy"}, {31'd0, bus.busy}, 0);
        chk({tag, " C"},    {31'd0, bus.C},    0);
        chk({tag, " cnt"},  {24'd0, bus.cnt},  0);
    endtask

    initial begin
        tbl[0]  = '{0, 3,  0, 0, 0, 0};
        tbl[1]  = '{1, 1,  0, 0, 1, 0};
        tbl[2]  = '{0, 4,  0, 0, 1, 4};
        tbl[3]  = '{0, 1,  1, 0, 1, 5};
        tbl[4]  = '{0, 14, 1, 0, 1, 19};
        tbl[5]  = '{0, 1,  1, 1, 0, 20};
        tbl[6]  = '{0, 30, 1, 1, 0, 20};
        tbl[7]  = '{1, 1,  0, 0, 1, 0};
        tbl[8]  = '{0, 10, 1, 0, 1, 10};
        tbl[9]  = '{1, 1,  0, 0, 1, 0};
        tbl[10] = '{0, 4,  0, 0, 1, 4};
        tbl[11] = '{0, 1,  1, 0, 1, 5};
        tbl[12] = '{0, 14, 1, 0, 1, 19};
        tbl[13] = '{0, 1,  1, 1, 0, 20};
        tbl[14] = '{4, 4,  0, 0, 1, 0};
        tbl[15] = '{0, 5,  1, 0, 1, 5};
        tbl[16] = '{0, 14, 1, 0, 1, 19};
        tbl[17] = '{0, 1,  1, 1, 0, 20};

        rst = 1'b0;
        bus.ST = 1'b1;
        c_raw = 1'b1;
        model_reset();
        repeat (4) begin
            @(posedge clk);
            #1 chk_zero("reset");
        end
        @(negedge clk);
        rst = 1'b1;
        bus.ST = 1'b0;
        c_raw = 1'b0;

        for (int i = 0; i < 18; i++) begin
            for (int c = 0; c < tbl[i].ncyc; c++) step(c < tbl[i].st_cyc, 1'b0);
            chk($sformatf("vec%0d TS", i),   {31'd0, bus.TS},   {31'd0, tbl[i].ts});
            chk($sformatf("vec%0d TL", i),   {31'd0, bus.TL},   {31'd0, tbl[i].tl});
            chk($sformatf("vec%0d busy", i), {31'd0, bus.busy}, {31'd0, tbl[i].busy});
            chk($sformatf("vec%0d cnt", i),  {24'd0, bus.cnt},  tbl[i].cnt);
        end

        repeat (2) step(1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0);
        chk("deb short pulse C", {31'd0, bus.C}, 0);
        repeat (4) step(1'b0, 1'b1);
        chk("deb rise e+3 C", {31'd0, bus.C}, 0);
        step(1'b0, 1'b1);
        chk("deb rise e+4 C", {31'd0, bus.C}, 1);
        repeat (5) step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        chk("deb fall f+3 C", {31'd0, bus.C}, 1);
        step(1'b0, 1'b0);
        chk("deb fall f+4 C", {31'd0, bus.C}, 0);

        begin
            bit cr = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 4) == 0) cr = 1'($urandom_range(0, 1));
                step($urandom_range(0, 29) == 0, cr);
            end
        end

        step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        chk("midrun cnt", {24'd0, bus.cnt}, 12);
        #1 rst = 1'b0;
        #1 chk_zero("midrun async");
        model_reset();
        @(posedge clk);
        #1 chk_zero("midrun held");
        @(negedge clk);
        rst = 1'b1;
        repeat (10) begin
            step(1'b0, 1'b0);
            chk("post reset TS", {31'd0, bus.TS}, 0);
            chk("post reset TL", {31'd0, bus.TL}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
